hspi_receiver: RTL
==================

HSPI_RECEIVER -- requirements
Module: hspi_receiver

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 1024, meaning payload words per packet.
REQ-002 SHALL have parameter CTS_HOLD, default 16, meaning the minimum number of cycles hspi_cts is held high after each packet.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all HSPI inputs are synchronous to it.
REQ-004 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port hrreq, input, 1 bit: transfer request from the sender.
REQ-006 SHALL have port hrrdy, output, 1 bit: receiver ready; grants the request.
REQ-007 SHALL have ports hrvld, input, 1 bit, and hrd, input, 32 bits: data-word valid strobe and data word.
REQ-008 SHALL have port hspi_cts, output, 1 bit: clear to send; 0 means a packet may be sent.
REQ-009 SHALL have port fifo_room, input, 1 bit: 1 when the downstream FIFO has at least PAYLOAD_LEN free words.
REQ-010 SHALL have ports fifo_write_en, output, 1 bit; fifo_write_data, output, 32 bits; fifo_full, input, 1 bit.
REQ-011 SHALL have ports pkt_ok, crc_err, hdr_err, seq_err, ovf_err and abort_err, all outputs, 1 bit each: one-cycle status pulses.
REQ-012 SHALL have port rx_seq, output, 4 bits: sequence number of the last accepted header.

Function
REQ-013 SHALL have the FSM states IDLE, GRANT, HEADER, PAYLOAD, CRC, DONE and HOLD.
REQ-014 IDLE: hspi_cts=0 only while fifo_room=1; on hrreq=1 with fifo_room=1, SHALL go to GRANT.
REQ-015 GRANT: SHALL drive hrrdy=1 and go to HEADER; hrrdy SHALL stay 1 until DONE.
REQ-016 Only cycles with hrvld=1 SHALL count as words; hrvld=0 gaps of any length SHALL be tolerated in HEADER, PAYLOAD and CRC.
REQ-017 HEADER: the word SHALL match hrd[31:30]=2'b11 and hrd[25:0]=26'h0A5A5A5, otherwise hdr_err pulses and the FSM goes to DONE with no FIFO writes.
REQ-018 The sequence field hrd[29:26] SHALL equal the previous rx_seq+1 mod 16, with the first packet after reset exempt; a mismatch pulses seq_err, the packet is still accepted, and rx_seq is always updated.
REQ-019 PAYLOAD: each valid word SHALL produce fifo_write_en=1 with fifo_write_data equal to that word exactly one cycle after sampling; this one-cycle latency is fixed.
REQ-020 A 10-bit word counter SHALL cover PAYLOAD_LEN words; after word PAYLOAD_LEN-1 the FSM SHALL go to CRC.
REQ-021 A valid payload word arriving while fifo_full=1 SHALL be dropped, not written, but counted; ovf_err pulses once per packet.
REQ-022 CRC: the next valid word is the trailer; the FSM then SHALL go to DONE and pulse the applicable status.
REQ-023 CRC definition: CRC-32, poly 0x04C11DB7, init 0xFFFFFFFF, over header plus payload words; each word is bit-reversed into the core and the result is bit-reversed and inverted.
REQ-024 If hrreq falls before the trailer is received, SHALL pulse abort_err and go to DONE; the words already written stay in the FIFO.
REQ-025 DONE: hrrdy=0, hspi_cts=1; pkt_ok SHALL pulse only if no error occurred in the packet; then go to HOLD.
REQ-026 HOLD: hspi_cts=1 for at least CTS_HOLD cycles and until hrreq=0 and fifo_room=1; then go to IDLE.
REQ-027 Simultaneous hrvld=1 and hrreq falling in the same cycle: the word SHALL be taken first and the abort then evaluated.

Reset
REQ-028 On sys_rst=1, SHALL go to IDLE with hrrdy=0, hspi_cts=1, fifo_write_en=0, fifo_write_data=0, all status pulses 0, rx_seq=0, the first-packet flag set, counters 0 and the CRC at its init value.
REQ-029 Reset mid-packet SHALL discard the packet silently with no status pulse.

Configuration
REQ-030 Macro HSPI_RX_CRC_CHECK_EN defined: the CRC is computed and compared, and a mismatch pulses crc_err and suppresses pkt_ok.
REQ-031 Macro HSPI_RX_CRC_CHECK_EN undefined: no CRC logic is built, the trailer word is consumed and ignored, and crc_err is tied to 0.

Structure
REQ-032 A shared package SHALL hold the state encoding, HDR_MAGIC=26'h0A5A5A5, HDR_TAG=2'b11, the CRC polynomial/init constants and the PAYLOAD_LEN default.
REQ-033 The CRC SHALL be the existing crc32_32b sub-module, instantiated only under HSPI_RX_CRC_CHECK_EN.

Verification
REQ-034 Good packet: header seq=0, payload 1..1024, correct CRC -> 1024 FIFO writes in order, pkt_ok=1 for one cycle, hspi_cts=1 for 16 or more cycles.
REQ-035 Gapped payload: hrvld=0 for 5 cycles after word 100 -> still 1024 writes, pkt_ok pulses.
REQ-036 CRC word XOR 0x1 with HSPI_RX_CRC_CHECK_EN defined -> crc_err pulses, no pkt_ok; with the macro undefined -> pkt_ok pulses.
REQ-037 Header 0x00A5A5A5 -> hdr_err pulses, 0 FIFO writes; sequence 0, 1, 3 -> seq_err on the third packet, rx_seq=3.
REQ-038 fifo_full=1 for words 10..12 -> 1021 writes and one ovf_err pulse; hrreq dropped after word 500 -> abort_err pulses and the FSM returns to IDLE.
REQ-039 sys_rst asserted after word 300 -> all outputs at reset values next cycle, and a following good packet yields pkt_ok with no seq_err.

Source files
------------

// File: rtl/hspi_receiver_pkg.sv
// Shared types and constants for the HSPI packet receiver.
// CRC helpers are only used when HSPI_RX_CRC_CHECK_EN is defined.
package hspi_receiver_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      HEADER,
      PAYLOAD,
      CRC,
      DONE,
      HOLD
   } state_t;

   localparam int          PAYLOAD_LEN_DEF = 1024;
   localparam logic [25:0] HDR_MAGIC       = 26'h0A5A5A5;
   localparam logic [1:0]  HDR_TAG         = 2'b11;
   localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

   function automatic logic [31:0] bitrev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = d[31-i];
      return r;
   endfunction

   // MSB-first CRC-32 core step over one 32-bit word
   function automatic logic [31:0] crc32_step(input logic [31:0] c,
                                              input logic [31:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 31; i >= 0; i--)
         r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
      return r;
   endfunction

endpackage

// File: rtl/crc32_32b.sv
// Word-wide CRC-32 accumulator; the data word is fed bit-reversed so the
// register holds the reflected-CRC state in non-reflected order.
module crc32_32b
   import hspi_receiver_pkg::*;
(
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        init,
   input  logic        en,
   input  logic [31:0] data,
   output logic [31:0] crc
);

   always_ff @(posedge sys_clk) begin
      if (sys_rst || init) crc <= CRC_INIT;
      else if (en)         crc <= crc32_step(crc, bitrev32(data));
   end

endmodule

// File: rtl/hspi_receiver.sv
// HSPI packet receiver: header check, payload to FIFO, trailer, CTS hold.
// Define HSPI_RX_CRC_CHECK_EN to build and check the CRC-32 trailer.
module hspi_receiver
   import hspi_receiver_pkg::*;
#(
   parameter int PAYLOAD_LEN = PAYLOAD_LEN_DEF,
   parameter int CTS_HOLD    = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        hrreq,
   output logic        hrrdy,
   input  logic        hrvld,
   input  logic [31:0] hrd,
   output logic        hspi_cts,
   input  logic        fifo_room,
   output logic        fifo_write_en,
   output logic [31:0] fifo_write_data,
   input  logic        fifo_full,
   output logic        pkt_ok,
   output logic        crc_err,
   output logic        hdr_err,
   output logic        seq_err,
   output logic        ovf_err,
   output logic        abort_err,
   output logic [3:0]  rx_seq
);

   state_t      state, state_n;
   logic [9:0]  cnt;
   logic [15:0] hold_cnt;
   logic        first, ovf_seen, err_seen;
   logic        take_hdr, take_pay, take_crc;
   logic        hdr_fail, abort, crc_bad;
   logic        hdr_ok, seq_bad, last_word;
   logic [3:0]  seq_in;

   assign seq_in    = hrd[29:26];
   assign hdr_ok    = (hrd[31:30] == HDR_TAG) && (hrd[25:0] == HDR_MAGIC);
   assign seq_bad   = !first && (seq_in != rx_seq + 4'd1);
   assign last_word = (cnt == 10'(PAYLOAD_LEN - 1));
   assign hrrdy     = (state == GRANT) || (state == HEADER) ||
                      (state == PAYLOAD) || (state == CRC);

`ifdef HSPI_RX_CRC_CHECK_EN
   logic [31:0] crc_q;

   crc32_32b u_crc (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .init    (state == GRANT),
      .en      (take_hdr || take_pay),
      .data    (hrd),
      .crc     (crc_q)
   );

   assign crc_bad = take_crc && (hrd != ~bitrev32(crc_q));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) crc_err <= 1'b0;
      else         crc_err <= crc_bad;
   end
`else
   assign crc_bad = 1'b0;
   assign crc_err = 1'b0;
`endif

   // A word arriving together with a falling hrreq is consumed before
   // the abort is taken.
   always_comb begin
      state_n  = state;
      take_hdr = 1'b0;
      take_pay = 1'b0;
      take_crc = 1'b0;
      hdr_fail = 1'b0;
      abort    = 1'b0;
      unique case (state)
         IDLE: if (hrreq && fifo_room) state_n = GRANT;
         GRANT: state_n = HEADER;
         HEADER: begin
            if (hrvld) begin
               take_hdr = 1'b1;
               if (!hdr_ok) begin
                  hdr_fail = 1'b1;
                  state_n  = DONE;
               end else if (!hrreq) begin
                  abort   = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = PAYLOAD;
               end
            end else if (!hrreq) begin
               abort   = 1'b1;
               state_n = DONE;
            end
         end
         PAYLOAD: begin
            take_pay = hrvld;
            if (hrvld && last_word) state_n = CRC;
            if (!hrreq) begin
               abort   = 1'b1;
               state_n = DONE;
            end
         end
         CRC: begin
            if (hrvld) begin
               take_crc = 1'b1;
               state_n  = DONE;
            end else if (!hrreq) begin
               abort   = 1'b1;
               state_n = DONE;
            end
         end
         DONE: state_n = HOLD;
         HOLD: begin
            if (hold_cnt >= 16'(CTS_HOLD - 1) && !hrreq && fifo_room)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state           <= IDLE;
         cnt             <= '0;
         hold_cnt        <= '0;
         first           <= 1'b1;
         ovf_seen        <= 1'b0;
         err_seen        <= 1'b0;
         rx_seq          <= '0;
         hspi_cts        <= 1'b1;
         fifo_write_en   <= 1'b0;
         fifo_write_data <= '0;
         pkt_ok          <= 1'b0;
         hdr_err         <= 1'b0;
         seq_err         <= 1'b0;
         ovf_err         <= 1'b0;
         abort_err       <= 1'b0;
      end else begin
         state         <= state_n;
         hspi_cts      <= !(state_n == IDLE && fifo_room);
         fifo_write_en <= take_pay && !fifo_full;
         if (take_pay && !fifo_full) fifo_write_data <= hrd;

         if (state == GRANT)  cnt <= '0;
         else if (take_pay)   cnt <= cnt + 10'd1;

         if (state != HOLD)          hold_cnt <= '0;
         else if (hold_cnt != '1)    hold_cnt <= hold_cnt + 16'd1;

         if (take_hdr && hdr_ok) begin
            rx_seq <= seq_in;
            first  <= 1'b0;
         end

         if (state == GRANT)                 ovf_seen <= 1'b0;
         else if (take_pay && fifo_full)     ovf_seen <= 1'b1;

         if (state == GRANT)
            err_seen <= 1'b0;
         else if ((take_hdr && hdr_ok && seq_bad) || (take_pay && fifo_full))
            err_seen <= 1'b1;

         pkt_ok    <= take_crc && !crc_bad && !err_seen;
         hdr_err   <= hdr_fail;
         seq_err   <= take_hdr && hdr_ok && seq_bad;
         ovf_err   <= take_pay && fifo_full && !ovf_seen;
         abort_err <= abort;
      end
   end

endmodule
